// File: rtl/uart_sample_pkg.sv
// Shared types and helpers for the UART byte-to-sample frame assembler.
package uart_sample_pkg;

    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    function automatic int nbytes(input int bps);
        return (bps + 7) / 8;
    endfunction

endpackage

// File: rtl/sample_out_reg.sv
// Valid/ready output register with load, accept and drop-count decision.
module sample_out_reg
    import uart_sample_pkg::*;
#(
    parameter int W = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [W-1:0]      data,
    input  logic              ready,
    output logic [W-1:0]      frame,
    output logic              valid,
    output logic [DROP_W-1:0] drop_count
);

    logic accept;
    logic room;

    assign accept = valid && ready;
    assign room   = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame      <= '0;
            valid      <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            frame <= '0;
            valid <= 1'b0;
        end else if (load) begin
            if (room) begin
                frame <= data;
                valid <= 1'b1;
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_sample_assembler.sv
// Packs UART bytes LSB-first into BPS-bit samples and CHANNELS-sample frames,
// with inter-byte timeout resync and back-pressured output register.
module uart_sample_assembler
    import uart_sample_pkg::*;
#(
    parameter int BPS          = 24,
    parameter int CHANNELS     = 2,
    parameter int TIMEOUT_CLKS = 12800
) (
    input  logic                    in_clk,
    input  logic                    in_reset_n,
    input  logic                    in_clear,
    input  logic                    in_uart_ready,
    input  logic [7:0]              in_uart_frame,
    output logic [CHANNELS*BPS-1:0] out_frame,
    output logic                    out_valid,
    input  logic                    in_ready,
    output logic                    out_resync,
    output logic [DROP_W-1:0]       out_drop_count
);

    localparam int NB  = nbytes(BPS);
    localparam int AW  = NB * 8;
    localparam int FW  = CHANNELS * BPS;
    localparam int BIW = $clog2(NB + 1);
    localparam int CIW = $clog2(CHANNELS + 1);
    localparam int IW  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [BIW-1:0] LAST_B = BIW'(NB - 1);
    localparam logic [CIW-1:0] LAST_C = CIW'(CHANNELS - 1);
    localparam logic [IW-1:0]  LAST_I = IW'(TIMEOUT_CLKS - 1);

    state_t         state;
    logic [BIW-1:0] byte_idx;
    logic [CIW-1:0] ch_idx;
    logic [IW-1:0]  idle_cnt;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_ins;
    logic [FW-1:0]  staging;
    logic           byte_ok;

    // A byte coinciding with a clear is deliberately dropped.
    assign byte_ok = in_uart_ready && !in_clear;

    always_comb begin
        acc_ins = acc;
        acc_ins[byte_idx*8 +: 8] = in_uart_frame;
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            ch_idx     <= '0;
            idle_cnt   <= '0;
            acc        <= '0;
            staging    <= '0;
            out_resync <= 1'b0;
        end else if (in_clear) begin
            state      <= IDLE;
            byte_idx   <= '0;
            ch_idx     <= '0;
            idle_cnt   <= '0;
            acc        <= '0;
            staging    <= '0;
            out_resync <= 1'b1;
        end else begin
            out_resync <= 1'b0;
            if (byte_ok) begin
                idle_cnt <= '0;
                if (byte_idx == LAST_B) begin
                    byte_idx <= '0;
                    acc      <= '0;
                    staging[ch_idx*BPS +: BPS] <= acc_ins[BPS-1:0];
                    if (ch_idx == LAST_C) begin
                        ch_idx <= '0;
                        state  <= COMMIT;
                    end else begin
                        ch_idx <= ch_idx + CIW'(1);
                        state  <= COLLECT;
                    end
                end else begin
                    byte_idx <= byte_idx + BIW'(1);
                    acc      <= acc_ins;
                    state    <= COLLECT;
                end
            end else begin
                if (idle_cnt != LAST_I) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
                if (state == COLLECT && idle_cnt == LAST_I) begin
                    state      <= IDLE;
                    byte_idx   <= '0;
                    ch_idx     <= '0;
                    acc        <= '0;
                    out_resync <= 1'b1;
                end else if (state == COMMIT) begin
                    state <= IDLE;
                end
            end
        end
    end

    sample_out_reg #(
        .W(FW)
    ) u_out (
        .clk        (in_clk),
        .rst_n      (in_reset_n),
        .clear      (in_clear),
        .load       (state == COMMIT),
        .data       (staging),
        .ready      (in_ready),
        .frame      (out_frame),
        .valid      (out_valid),
        .drop_count (out_drop_count)
    );

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Directed self-checking bench for uart_sample_assembler (24x2 and 12x1).
module tb_uart_sample_assembler;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;

    logic        uart_ready_a = 1'b0;
    logic [7:0]  uart_frame_a = 8'h00;
    logic        in_ready_a = 1'b1;
    logic [47:0] out_frame_a;
    logic        out_valid_a;
    logic        out_resync_a;
    logic [15:0] drop_a;

    logic        uart_ready_b = 1'b0;
    logic [7:0]  uart_frame_b = 8'h00;
    logic        in_ready_b = 1'b1;
    logic [11:0] out_frame_b;
    logic        out_valid_b;
    logic        out_resync_b;
    logic [15:0] drop_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_sample_assembler #(
        .BPS(24), .CHANNELS(2), .TIMEOUT_CLKS(TO)
    ) dut_a (
        .in_clk         (clk),
        .in_reset_n     (rst_n),
        .in_clear       (clear),
        .in_uart_ready  (uart_ready_a),
        .in_uart_frame  (uart_frame_a),
        .out_frame      (out_frame_a),
        .out_valid      (out_valid_a),
        .in_ready       (in_ready_a),
        .out_resync     (out_resync_a),
        .out_drop_count (drop_a)
    );

    uart_sample_assembler #(
        .BPS(12), .CHANNELS(1), .TIMEOUT_CLKS(TO)
    ) dut_b (
        .in_clk         (clk),
        .in_reset_n     (rst_n),
        .in_clear       (clear),
        .in_uart_ready  (uart_ready_b),
        .in_uart_frame  (uart_frame_b),
        .out_frame      (out_frame_b),
        .out_valid      (out_valid_b),
        .in_ready       (in_ready_b),
        .out_resync     (out_resync_b),
        .out_drop_count (drop_b)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        uart_ready_a = 1'b1;
        uart_frame_a = b;
        tick();
        uart_ready_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        uart_ready_b = 1'b1;
        uart_frame_b = b;
        tick();
        uart_ready_b = 1'b0;
    endtask

    logic [47:0] exp_f [4];
    int          nseen;
    int          k;
    bit          saw;

    initial begin
        // reset state
        #2;
        check("rst_frame_a", out_frame_a, 0);
        check("rst_valid_a", out_valid_a, 0);
        check("rst_resync_a", out_resync_a, 0);
        check("rst_drop_a", drop_a, 0);
        check("rst_valid_b", out_valid_b, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic 24x2 frame, latency 2
        for (int i = 1; i <= 6; i++) send_a(8'(i));
        check("t1_valid_lat1", out_valid_a, 0);
        tick();
        check("t1_valid", out_valid_a, 1);
        check("t1_frame", out_frame_a, 48'h060504030201);
        tick();
        check("t1_valid_fall", out_valid_a, 0);
        check("t1_drop", drop_a, 0);

        // 12-bit sample, upper nibble of last byte dropped
        send_b(8'hAB);
        send_b(8'hCD);
        check("t2_valid_lat1", out_valid_b, 0);
        tick();
        check("t2_valid", out_valid_b, 1);
        check("t2_frame", out_frame_b, 12'hDAB);
        tick();
        check("t2_valid_fall", out_valid_b, 0);

        // back-pressure: three frames, two dropped
        in_ready_a = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            uart_ready_a = 1'b1;
            uart_frame_a = 8'(i);
            tick();
        end
        uart_ready_a = 1'b0;
        tick();
        check("t3_drop", drop_a, 2);
        check("t3_valid_held", out_valid_a, 1);
        check("t3_frame_held", out_frame_a, 48'h060504030201);
        in_ready_a = 1'b1;
        tick();
        check("t3_consumed", out_valid_a, 0);

        // timeout after partial frame
        send_a(8'h11);
        send_a(8'h22);
        k = 0;
        for (int i = 1; i <= 4 * TO && k == 0; i++) begin
            tick();
            if (out_resync_a) k = i;
        end
        check("t4_timeout_at", k, TO);
        tick();
        check("t4_resync_pulse", out_resync_a, 0);
        for (int i = 0; i < 6; i++) send_a(8'(8'hA1 + i));
        tick();
        check("t4_valid", out_valid_a, 1);
        check("t4_frame", out_frame_a, 48'hA6A5A4A3A2A1);
        tick();

        // byte in the exact expiry cycle wins
        send_a(8'h11);
        saw = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (out_resync_a) saw = 1'b1;
        end
        check("t5_no_early_resync", saw, 0);
        send_a(8'h22);
        check("t5_no_resync", out_resync_a, 0);
        send_a(8'h33);
        tick();
        check("t5_no_resync2", out_resync_a, 0);

        // reset mid-frame
        rst_n = 1'b0;
        #1;
        check("t5_rst_frame", out_frame_a, 0);
        check("t5_rst_valid", out_valid_a, 0);
        check("t5_rst_drop", drop_a, 0);
        check("t5_rst_resync", out_resync_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send_a(8'(8'hB1 + i));
        tick();
        check("t5_valid", out_valid_a, 1);
        check("t5_frame", out_frame_a, 48'hB6B5B4B3B2B1);
        tick();

        // back-to-back strobes across COMMIT
        exp_f[0] = 48'hC6C5C4C3C2C1;
        exp_f[1] = 48'hCCCBCAC9C8C7;
        exp_f[2] = 48'h0;
        exp_f[3] = 48'h0;
        nseen = 0;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) begin
                uart_ready_a = 1'b1;
                uart_frame_a = 8'(8'hC1 + i);
            end else begin
                uart_ready_a = 1'b0;
            end
            tick();
            if (out_valid_a) begin
                if (nseen < 4) check("t6_frame", out_frame_a, exp_f[nseen]);
                nseen++;
            end
        end
        check("t6_count", nseen, 2);
        check("t6_drop", drop_a, 0);

        // clear discards partial, output and same-cycle byte
        in_ready_a = 1'b0;
        for (int i = 0; i < 6; i++) send_a(8'(8'hD1 + i));
        tick();
        check("t7_loaded", out_valid_a, 1);
        send_a(8'hE1);
        send_a(8'hE2);
        clear = 1'b1;
        uart_ready_a = 1'b1;
        uart_frame_a = 8'hE3;
        tick();
        clear = 1'b0;
        uart_ready_a = 1'b0;
        check("t7_valid_cleared", out_valid_a, 0);
        check("t7_frame_cleared", out_frame_a, 0);
        check("t7_resync", out_resync_a, 1);
        check("t7_drop_kept", drop_a, 0);
        tick();
        check("t7_resync_pulse", out_resync_a, 0);
        in_ready_a = 1'b1;
        for (int i = 0; i < 6; i++) send_a(8'(8'hF1 + i));
        tick();
        check("t7_valid", out_valid_a, 1);
        check("t7_frame", out_frame_a, 48'hF6F5F4F3F2F1);
        tick();
        check("t7_valid_fall", out_valid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_sample_assembler.md
# uart_sample_assembler

Parametrised successor to the single-channel UART-to-sample path. It collects the byte stream from `uart_rx`, packs it LSB-first into `BPS`-bit samples, and groups `CHANNELS` samples into one frame. Each frame is presented on a valid/ready output register. Unlike the previous path, it resynchronises on inter-byte timeout, applies back-pressure, and counts dropped frames; it sits between `uart_rx` and `bit_changer_seq` / `fifo_buffer`.

## Interface
- `BPS`, 24, bits per sample (8..32); `NBYTES = ceil(BPS/8)` bytes per sample.
- `CHANNELS`, 2, samples per frame (1..8).
- `TIMEOUT_CLKS`, 12800, idle clocks that abort a partial frame (two byte times at `CLKS_PER_BIT` = 640).
- `in_clk`  in  1  system clock (`internal_clk` domain).
- `in_reset_n`  in  1  asynchronous, active-low reset.
- `in_clear`  in  1  synchronous clear of the partial frame and the output register.
- `in_uart_ready`  in  1  one-cycle strobe: `in_uart_frame` is valid.
- `in_uart_frame`  in  8  received byte.
- `out_frame`  out  CHANNELS*BPS  assembled frame; channel k occupies bits [k*BPS +: BPS].
- `out_valid`  out  1  `out_frame` holds an unconsumed frame.
- `in_ready`  in  1  downstream accepts the frame when `out_valid && in_ready`.
- `out_resync`  out  1  one-cycle pulse when a partial frame is discarded.
- `out_drop_count`  out  16  saturating count of completed frames that were lost.

## Operation
- Counters: `byte_idx` (0..NBYTES-1) and `ch_idx` (0..CHANNELS-1), plus a `BPS`-bit shift accumulator and a `CHANNELS*BPS` staging register.
- State machine:
  - IDLE: `byte_idx` = 0, `ch_idx` = 0. A byte strobe moves to COLLECT.
  - COLLECT: a partial frame is in progress.
  - COMMIT: one cycle; the staging register is transferred to the output register. Returns to IDLE.
- Packing order: the first byte of a sample is the LSB. Byte j fills bits [8j +: 8]. Bits of the final byte above `BPS` are discarded.
- Sample completion: when `byte_idx` wraps, the sample is written to staging slot `ch_idx`, and `ch_idx` increments.
- Frame completion: completing the sample in slot `CHANNELS-1` enters COMMIT.
- COMMIT behaviour:
  - If the output register is empty, or is being consumed this cycle (`in_ready` = 1), load it and set `out_valid` = 1.
  - Otherwise keep the old frame, discard the new one, and increment `out_drop_count`. The count saturates at 0xFFFF.
- Byte strobe during COMMIT: accepted and counted as byte 0 of the next frame. No byte is ever lost.
- Timeout: the idle counter resets on every byte. If it reaches `TIMEOUT_CLKS`-1 while in COLLECT with no byte that cycle:
  - return to IDLE and clear the accumulator;
  - pulse `out_resync`.
- Timeout and byte arriving in the same cycle: the byte wins and no resync occurs.
- `in_clear`: clears the partial frame and the output register (`out_valid` = 0) and pulses `out_resync`. `out_drop_count` is kept. A byte strobe in the same cycle is discarded.
- Reset values: all registers 0. `out_frame` = 0, `out_valid` = 0, `out_resync` = 0, `out_drop_count` = 0, state IDLE. Reset may assert mid-frame; there is no recovery of the partial data.

## Timing
- Latency: `out_valid` rises 2 cycles after the strobe carrying the last byte of the frame (1 cycle to the COMMIT state, then the register update).
- `out_frame` and `out_valid` are registered and remain stable until the handshake.
- On handshake, `out_valid` falls the next cycle, unless a COMMIT coincides with it, in which case it stays high with the new frame.
- Throughput: one byte per cycle is supported, including back-to-back strobes.
- `out_resync` is high for exactly one cycle per event.

## Structure
- Shared package `uart_sample_pkg`:
  - `NBYTES` computation function;
  - the state enum (IDLE, COLLECT, COMMIT);
  - the drop-counter width constant (16).
- Natural sub-module `sample_out_reg`: the valid/ready output register with a load/accept/drop decision. It is reused later by the `sample_switch` successor.
- Instantiated in `main` in place of `uart2sample`. The `main` active-high `in_reset` is inverted to drive `in_reset_n`.

## Test plan
- BPS=24, CHANNELS=2, `in_ready`=1; bytes 01 02 03 04 05 06 -> `out_frame` = 0x060504_030201, one-cycle `out_valid` 2 cycles after the 06 strobe.
- BPS=12, CHANNELS=1; bytes AB CD -> `out_frame` = 0xDAB (upper nibble of CD dropped).
- `in_ready`=0, 18 bytes (3 frames of 6) -> first frame held, `out_drop_count` = 2; assert `in_ready` -> frame 1 consumed, `out_valid` = 0.
- Bytes 11 22, idle for `TIMEOUT_CLKS` cycles -> one `out_resync` pulse; next 6 bytes form a correct frame starting at 0x..._..2211 replaced by the new data.
- Strobe in the exact expiry cycle -> no resync; reset asserted after 3 bytes -> all outputs 0; 6 new bytes -> correct frame.
- Back-to-back strobes every cycle across a COMMIT, with `in_ready`=1 -> every frame delivered, `out_drop_count` = 0.
